// File: rtl/wb_arbiter_pkg.sv
// Shared types and constants for the dual-lane writeback arbiter.
package wb_arbiter_pkg;

    localparam int         WB_DEPTH_DEFAULT = 4;
    localparam logic [4:0] REG_ZERO         = 5'd0;

    typedef struct packed {
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } wb_entry_t;

    function automatic logic [31:0] wb_select_data(
        input logic        mem_to_reg,
        input logic [31:0] read_data,
        input logic [31:0] alu_result
    );
        return mem_to_reg ? read_data : alu_result;
    endfunction

endpackage

// File: rtl/wb_queue.sv
// Generic FIFO accepting up to two pushes and one pop per cycle; push0 lands before push1.
module wb_queue
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH_DEFAULT,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_push0,
    input  wb_entry_t     i_data0,
    input  logic          i_push1,
    input  wb_entry_t     i_data1,
    input  logic          i_pop,
    output wb_entry_t     o_head,
    output logic [CW-1:0] o_count
);

    localparam logic [AW:0]   PTR_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]   PTR_TWO = {{(AW - 1){1'b0}}, 2'b10};
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

    wb_entry_t     r_mem [DEPTH];
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic [CW-1:0] r_count;

    logic [AW:0]   w_slot1;
    logic [AW:0]   w_wr_ptr_next;
    logic [CW-1:0] w_count_next;

    // Slot for push1 and next-state pointer/occupancy arithmetic (pointers keep one extra wrap bit).
    always_comb begin
        w_slot1       = r_wr_ptr;
        w_wr_ptr_next = r_wr_ptr;
        w_count_next  = r_count;
        if (i_push0) begin
            w_slot1 = r_wr_ptr + PTR_ONE;
        end else begin
            w_slot1 = r_wr_ptr;
        end
        if (i_push0 && i_push1) begin
            w_wr_ptr_next = r_wr_ptr + PTR_TWO;
        end else if (i_push0 || i_push1) begin
            w_wr_ptr_next = r_wr_ptr + PTR_ONE;
        end else begin
            w_wr_ptr_next = r_wr_ptr;
        end
        w_count_next = r_count
                     + {{(CW - 1){1'b0}}, i_push0}
                     + {{(CW - 1){1'b0}}, i_push1}
                     - {{(CW - 1){1'b0}}, i_pop};
    end

    // Pointer and occupancy state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= {(AW + 1){1'b0}};
            r_rd_ptr <= {(AW + 1){1'b0}};
            r_count  <= CNT_ZERO;
        end else begin
            r_wr_ptr <= w_wr_ptr_next;
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            r_count <= w_count_next;
        end
    end

    // Storage; contents are don't-care after reset so no reset term.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (i_push0) begin
                r_mem[r_wr_ptr[AW-1:0]] <= i_data0;
            end
            if (i_push1) begin
                r_mem[w_slot1[AW-1:0]] <= i_data1;
            end
        end
    end

    assign o_head  = r_mem[r_rd_ptr[AW-1:0]];
    assign o_count = r_count;

endmodule

// File: rtl/wb_arbiter.sv
// Dual-lane writeback arbiter: muxes, filters $zero writes and serialises both lanes into one RF port.
// Optional WB_WAW_SQUASH_EN: same-register dual writes keep only the younger lane.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int WB_DEPTH = WB_DEPTH_DEFAULT,
    localparam int CW = $clog2(WB_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          MemToReg0_in,
    input  logic          MemToReg1_in,
    input  logic          RegWrite0_in,
    input  logic          RegWrite1_in,
    input  logic [31:0]   alu_result0_in,
    input  logic [31:0]   alu_result1_in,
    input  logic [31:0]   read_data0_in,
    input  logic [31:0]   read_data1_in,
    input  logic [4:0]    write_reg0_in,
    input  logic [4:0]    write_reg1_in,
    output logic          stall_out,
    output logic          rf_we,
    output logic [4:0]    rf_waddr,
    output logic [31:0]   rf_wdata,
    output logic [CW-1:0] count_out
);

    localparam logic [CW-1:0] STALL_AT = CW'(WB_DEPTH - 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

    wb_entry_t     w_entry0;
    wb_entry_t     w_entry1;
    wb_entry_t     w_head;
    logic          w_cand0;
    logic          w_cand1;
    logic          w_squash;
    logic          w_push0;
    logic          w_push1;
    logic          w_pop;
    logic [CW-1:0] w_count;

    // Lane muxing, candidate filtering and squash decision.
    always_comb begin
        w_entry0.waddr = write_reg0_in;
        w_entry0.wdata = wb_select_data(MemToReg0_in, read_data0_in, alu_result0_in);
        w_entry1.waddr = write_reg1_in;
        w_entry1.wdata = wb_select_data(MemToReg1_in, read_data1_in, alu_result1_in);
        w_cand0 = RegWrite0_in && (write_reg0_in != REG_ZERO);
        w_cand1 = RegWrite1_in && (write_reg1_in != REG_ZERO);
`ifdef WB_WAW_SQUASH_EN
        w_squash = w_cand0 && w_cand1 && (write_reg0_in == write_reg1_in);
`else
        w_squash = 1'b0;
`endif
        // Inputs on the reset edge and while stalled never reach the queue.
        w_push0 = !reset && !stall_out && w_cand0 && !w_squash;
        w_push1 = !reset && !stall_out && w_cand1;
    end

    // Stall depends only on registered occupancy; the head drains whenever present.
    always_comb begin
        stall_out = (w_count >= STALL_AT);
        rf_we     = (w_count != CNT_ZERO) && !reset;
        w_pop     = rf_we;
        rf_waddr  = w_head.waddr;
        rf_wdata  = w_head.wdata;
        count_out = w_count;
    end

    wb_queue #(
        .DEPTH (WB_DEPTH)
    ) u_queue (
        .clk     (clk),
        .reset   (reset),
        .i_push0 (w_push0),
        .i_data0 (w_entry0),
        .i_push1 (w_push1),
        .i_data1 (w_entry1),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_count)
    );

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter (WB_DEPTH = 4).
module tb_wb_arbiter;

    logic        clk;
    logic        reset;
    logic        MemToReg0_in, MemToReg1_in;
    logic        RegWrite0_in, RegWrite1_in;
    logic [31:0] alu_result0_in, alu_result1_in;
    logic [31:0] read_data0_in, read_data1_in;
    logic [4:0]  write_reg0_in, write_reg1_in;
    logic        stall_out;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [2:0]  count_out;

    int n_checks;
    int n_fail;

    wb_arbiter #(.WB_DEPTH(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .MemToReg0_in   (MemToReg0_in),
        .MemToReg1_in   (MemToReg1_in),
        .RegWrite0_in   (RegWrite0_in),
        .RegWrite1_in   (RegWrite1_in),
        .alu_result0_in (alu_result0_in),
        .alu_result1_in (alu_result1_in),
        .read_data0_in  (read_data0_in),
        .read_data1_in  (read_data1_in),
        .write_reg0_in  (write_reg0_in),
        .write_reg1_in  (write_reg1_in),
        .stall_out      (stall_out),
        .rf_we          (rf_we),
        .rf_waddr       (rf_waddr),
        .rf_wdata       (rf_wdata),
        .count_out      (count_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane0(input logic rw, input logic mtr, input logic [4:0] rg,
                             input logic [31:0] alu, input logic [31:0] rd);
        RegWrite0_in = rw; MemToReg0_in = mtr; write_reg0_in = rg;
        alu_result0_in = alu; read_data0_in = rd;
    endtask

    task automatic set_lane1(input logic rw, input logic mtr, input logic [4:0] rg,
                             input logic [31:0] alu, input logic [31:0] rd);
        RegWrite1_in = rw; MemToReg1_in = mtr; write_reg1_in = rg;
        alu_result1_in = alu; read_data1_in = rd;
    endtask

    task automatic idle();
        set_lane0(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        set_lane1(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    endtask

    task automatic check_head(input string tag, input logic [4:0] rg, input logic [31:0] d);
        check_val({tag, "_we"}, {31'd0, rf_we}, 32'd1);
        check_val({tag, "_waddr"}, {27'd0, rf_waddr}, {27'd0, rg});
        check_val({tag, "_wdata"}, rf_wdata, d);
    endtask

    logic [36:0] got_q[$];
    int          exp_cnt[7]   = '{2, 3, 2, 3, 2, 1, 0};
    int          exp_stall[7] = '{0, 1, 0, 1, 0, 0, 0};

    initial begin
        n_checks = 0;
        n_fail   = 0;
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check_val("rst_count", {29'd0, count_out}, 32'd0);
        check_val("rst_we", {31'd0, rf_we}, 32'd0);
        check_val("rst_stall", {31'd0, stall_out}, 32'd0);

        // Single lane 0 write of reg 5
        set_lane0(1'b1, 1'b0, 5'd5, 32'h11, 32'h99);
        tick();
        idle();
        check_head("single", 5'd5, 32'h11);
        check_val("single_cnt1", {29'd0, count_out}, 32'd1);
        tick();
        check_val("single_cnt0", {29'd0, count_out}, 32'd0);
        check_val("single_we0", {31'd0, rf_we}, 32'd0);

        // Lane 0 reading memory data
        set_lane0(1'b1, 1'b1, 5'd9, 32'h12, 32'hDEADBEEF);
        tick();
        idle();
        check_head("mem0", 5'd9, 32'hDEADBEEF);
        tick();

        // Both lanes, reg 3 (ALU) then reg 4 (memory 0xAA)
        set_lane0(1'b1, 1'b0, 5'd3, 32'h33, 32'h55);
        set_lane1(1'b1, 1'b1, 5'd4, 32'h44, 32'hAA);
        tick();
        idle();
        check_val("dual_cnt2", {29'd0, count_out}, 32'd2);
        check_head("dual_first", 5'd3, 32'h33);
        tick();
        check_head("dual_second", 5'd4, 32'hAA);
        tick();
        check_val("dual_cnt0", {29'd0, count_out}, 32'd0);

        // Three consecutive dual-write pairs against a depth-4 queue
        begin
            int p;
            p = 0;
            for (int c = 0; c < 12; c++) begin
                logic took;
                if (p < 3) begin
                    set_lane0(1'b1, 1'b0, 5'(8 + 2 * p), 32'(32'h100 + 8 + 2 * p), 32'h0);
                    set_lane1(1'b1, 1'b0, 5'(9 + 2 * p), 32'(32'h100 + 9 + 2 * p), 32'h0);
                end else begin
                    idle();
                end
                if (rf_we) got_q.push_back({rf_waddr, rf_wdata});
                took = (p < 3) && !stall_out;
                tick();
                if (took) p++;
                if (c < 7) begin
                    check_val($sformatf("burst_cnt%0d", c), {29'd0, count_out}, 32'(exp_cnt[c]));
                    check_val($sformatf("burst_stall%0d", c), {31'd0, stall_out}, 32'(exp_stall[c]));
                end
            end
            idle();
            check_val("burst_nwrites", 32'(got_q.size()), 32'd6);
            for (int i = 0; i < 6; i++) begin
                if (i < got_q.size()) begin
                    check_val($sformatf("burst_wr%0d", i), {27'd0, got_q[i][36:32]}, 32'(8 + i));
                    check_val($sformatf("burst_wd%0d", i), got_q[i][31:0], 32'(32'h100 + 8 + i));
                end
            end
        end

        // Same destination on both lanes
        set_lane0(1'b1, 1'b0, 5'd7, 32'h1, 32'h0);
        set_lane1(1'b1, 1'b0, 5'd7, 32'h2, 32'h0);
        tick();
        idle();
`ifdef WB_WAW_SQUASH_EN
        check_val("waw_cnt", {29'd0, count_out}, 32'd1);
        check_head("waw_only", 5'd7, 32'h2);
        tick();
`else
        check_val("waw_cnt", {29'd0, count_out}, 32'd2);
        check_head("waw_first", 5'd7, 32'h1);
        tick();
        check_head("waw_second", 5'd7, 32'h2);
        tick();
`endif
        check_val("waw_cnt0", {29'd0, count_out}, 32'd0);

        // Writes to $zero are dropped
        set_lane0(1'b1, 1'b0, 5'd0, 32'h5, 32'h0);
        set_lane1(1'b1, 1'b0, 5'd0, 32'h6, 32'h0);
        tick();
        idle();
        check_val("zero_cnt", {29'd0, count_out}, 32'd0);
        check_val("zero_we", {31'd0, rf_we}, 32'd0);
        set_lane0(1'b1, 1'b0, 5'd0, 32'h5, 32'h0);
        set_lane1(1'b1, 1'b0, 5'd6, 32'h66, 32'h0);
        tick();
        idle();
        check_val("mixzero_cnt", {29'd0, count_out}, 32'd1);
        check_head("mixzero", 5'd6, 32'h66);
        tick();

        // Reset with three entries queued and a candidate on the reset edge
        set_lane0(1'b1, 1'b0, 5'd10, 32'hA0, 32'h0);
        set_lane1(1'b1, 1'b0, 5'd11, 32'hA1, 32'h0);
        tick();
        set_lane0(1'b1, 1'b0, 5'd12, 32'hA2, 32'h0);
        set_lane1(1'b1, 1'b0, 5'd13, 32'hA3, 32'h0);
        tick();
        check_val("prerst_cnt", {29'd0, count_out}, 32'd3);
        reset = 1'b1;
        #1;
        check_val("inrst_we", {31'd0, rf_we}, 32'd0);
        tick();
        reset = 1'b0;
        idle();
        #1;
        check_val("postrst_cnt", {29'd0, count_out}, 32'd0);
        check_val("postrst_we", {31'd0, rf_we}, 32'd0);
        check_val("postrst_stall", {31'd0, stall_out}, 32'd0);
        tick();
        check_val("postrst_cnt2", {29'd0, count_out}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter WB_DEPTH, default 4: queue entries; power of two, >=2.
REQ-002 clk  input  1  sole clock, rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 MemToReg0_in / MemToReg1_in  input  1  lane 0 (older) / lane 1 (younger): select read data over ALU result.
REQ-005 RegWrite0_in / RegWrite1_in  input  1  lane 0 / lane 1 writeback request this cycle.
REQ-006 alu_result0_in / alu_result1_in  input  32  ALU result, lane 0 / lane 1.
REQ-007 read_data0_in / read_data1_in  input  32  memory read data, lane 0 / lane 1.
REQ-008 write_reg0_in / write_reg1_in  input  5  destination register, lane 0 / lane 1.
REQ-009 stall_out  output  1  upstream shall hold both lanes; inputs ignored while high.
REQ-010 rf_we  output  1  register-file write enable.
REQ-011 rf_waddr  output  5  register-file write address.
REQ-012 rf_wdata  output  32  register-file write data.
REQ-013 count_out  output  log2(WB_DEPTH)+1  current occupancy.

Function
REQ-014 Per lane, data = MemToReg ? read_data : alu_result, muxed before enqueue.
REQ-015 Enqueue candidate: lane with RegWrite high and write_reg != 0; writes to $zero are dropped, never queued.
REQ-016 When stall_out is low, candidates enqueue on the same edge in program order: lane 0, then lane 1.
REQ-017 rf_we/rf_waddr/rf_wdata are combinational from the queue head: rf_we = (count != 0). Head dequeues on every edge with rf_we high.
REQ-018 Latency: an entry enqueued at edge N into an empty queue drives rf_* during cycle N..N+1. It is written at edge N+1.
REQ-019 Drain rate: one write per cycle. Order is strictly program order.
REQ-020 stall_out = (WB_DEPTH - count) < 2, combinational from registered count only. No input-to-stall path.
REQ-021 Simultaneous enqueue and dequeue on one edge: count += enq_n - 1. Full queue with dequeue and no enqueue gives count = WB_DEPTH-1.
REQ-022 Read and write pointers wrap modulo WB_DEPTH. The pointer is 1 bit wider than the index, so full and empty are distinguishable.
REQ-023 Enqueue while stall_out is high has no effect.

Reset
REQ-024 On reset: pointers = 0, count_out = 0, rf_we = 0, stall_out = 0. Queue contents are don't-care.
REQ-025 Reset mid-operation discards all queued writes with no register-file write on that edge. Inputs on the reset edge are dropped.

Configuration
REQ-026 WB_WAW_SQUASH_EN defined: when both lanes are candidates with equal write_reg, only lane 1 is enqueued.
REQ-027 WB_WAW_SQUASH_EN undefined: both lanes are enqueued and written in order, lane 0 first.

Structure
REQ-028 Shared package holds the queue-entry typedef {waddr[4:0], wdata[31:0]}, the REG_ZERO constant and the WB_DEPTH default.
REQ-029 One sub-module, wb_queue: a generic FIFO with push0/push1/pop, count, and wrap logic. wb_arbiter holds the muxing, filtering, squash and stall.

Verification
REQ-030 Lane 0 only, reg 5, ALU 0x11: rf_we = 1, waddr = 5, wdata = 0x11 in the next cycle. Count returns to 0.
REQ-031 Both lanes in one cycle, regs 3 and 4, MemToReg1 = 1, read_data1 = 0xAA: reg 3 is written, then reg 4 = 0xAA on consecutive edges.
REQ-032 Dual writes for 3 consecutive cycles, WB_DEPTH = 4: stall_out rises when count >= 3. No entry is lost, and 6 writes emerge in order.
REQ-033 Both lanes write reg 7 (0x1, then 0x2): with the macro, one write of 0x2. Without it, 0x1 is written, then 0x2.
REQ-034 RegWrite to reg 0 on both lanes: no enqueue, and rf_we stays 0.
REQ-035 Reset asserted with count = 3: next cycle count = 0, rf_we = 0, stall_out = 0.
